// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and encodings for the front end.
// Provides the decoded instruction record (decoded_inst_t) handed from
// decode to rename, plus the RV32 opcode / funct constants decode relies on.
package uarch_pkg;

    localparam int CPU_ADDR_BITS = 32;
    localparam int CPU_INST_BITS = 32;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_CSR       = 7'b1110011;

    localparam logic [6:0] FNC7_MULDIV  = 7'b0000001;
    localparam logic [6:0] FNC7_SUB_SRA = 7'b0100000;
    localparam logic [2:0] FNC_ADD_SUB  = 3'b000;

    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0] pc;
        logic [31:0]              imm;
        logic [4:0]               rd;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [3:0]               uop;
        logic [2:0]               uop_br;
        logic                     is_valid;
        logic                     has_rd;
        logic                     is_branch;
        logic                     is_jump;
        logic                     is_load;
        logic                     is_store;
        logic                     is_muldiv;
        logic                     alu_a_sel;
        logic                     alu_b_sel;
    } decoded_inst_t;

endpackage

// File: rtl/decode_n_if.sv
// Fetch -> decode -> rename bundle interface for the N-wide decode stage.
//   master : fetch/rename side (drives fetch bundle, flush, stall, take count)
//   slave  : decode stage (drives decode_rdy, decode_inst, decode_val)
interface decode_n_if #(
    parameter int DEC_WIDTH = 2
);
    import uarch_pkg::*;

    localparam int TAKE_W = $clog2(DEC_WIDTH + 1);

    logic                                         flush;
    logic                                         cache_stall;
    logic [DEC_WIDTH-1:0][CPU_ADDR_BITS-1:0]      fetch_pc;
    logic [DEC_WIDTH-1:0][CPU_INST_BITS-1:0]      fetch_inst;
    logic [DEC_WIDTH-1:0]                         fetch_mask;
    logic                                         fetch_val;
    logic                                         decode_rdy;
    decoded_inst_t [DEC_WIDTH-1:0]                decode_inst;
    logic [DEC_WIDTH-1:0]                         decode_val;
    logic [TAKE_W-1:0]                            rename_take;

    modport master (
        output flush, cache_stall, fetch_pc, fetch_inst, fetch_mask, fetch_val, rename_take,
        input  decode_rdy, decode_inst, decode_val
    );

    modport slave (
        input  flush, cache_stall, fetch_pc, fetch_inst, fetch_mask, fetch_val, rename_take,
        output decode_rdy, decode_inst, decode_val
    );

endinterface

// File: rtl/decode_n.sv
// Parametrised superscalar decode stage between fetch and rename.
// Decodes up to DEC_WIDTH instructions per bundle, compacts the masked-valid
// slots to the oldest positions and holds them in a registered bundle.
// Rename may consume fewer than all held entries; leftovers shift down and
// a new bundle is only accepted once the held bundle fully drains.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   dif      : decode_n_if slave (fetch bundle in, decoded bundle out,
//              flush / cache_stall / rename_take control)
module decode_n
    import uarch_pkg::*;
#(
    parameter int DEC_WIDTH = 2,
    parameter int SUPPORT_M = 1
) (
    input  logic      clk,
    input  logic      rst,
    decode_n_if.slave dif
);

    localparam int TAKE_W = $clog2(DEC_WIDTH + 1);

    function automatic decoded_inst_t dec_one(input logic [CPU_ADDR_BITS-1:0] pc,
                                              input logic [CPU_INST_BITS-1:0] inst);
        decoded_inst_t d;
        logic [6:0]    opc;
        logic [2:0]    f3;
        logic [6:0]    f7;
        logic [31:0]   imm_i;
        logic [31:0]   imm_s;
        logic [31:0]   imm_b;
        logic [31:0]   imm_u;
        logic [31:0]   imm_j;
        opc   = inst[6:0];
        f3    = inst[14:12];
        f7    = inst[31:25];
        imm_i = {{20{inst[31]}}, inst[31:20]};
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u = {inst[31:12], 12'b0};
        imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

        d           = '0;
        d.pc        = pc;
        d.rd        = inst[11:7];
        d.rs1       = inst[19:15];
        d.rs2       = inst[24:20];
        d.alu_b_sel = 1'b1;
        d.uop       = {1'b0, FNC_ADD_SUB};
        case (opc)
            OPC_LUI: begin
                d.is_valid = 1'b1; d.has_rd = 1'b1; d.imm = imm_u;
            end
            OPC_AUIPC: begin
                d.is_valid = 1'b1; d.has_rd = 1'b1; d.alu_a_sel = 1'b1; d.imm = imm_u;
            end
            OPC_JAL: begin
                d.is_valid = 1'b1; d.has_rd = 1'b1; d.is_jump = 1'b1;
                d.alu_a_sel = 1'b1; d.imm = imm_j;
            end
            OPC_JALR: begin
                d.is_valid = 1'b1; d.has_rd = 1'b1; d.is_jump = 1'b1; d.imm = imm_i;
            end
            OPC_BRANCH: begin
                d.is_valid = 1'b1; d.is_branch = 1'b1; d.alu_a_sel = 1'b1;
                d.imm = imm_b; d.uop_br = f3;
            end
            OPC_LOAD: begin
                d.is_valid = 1'b1; d.has_rd = 1'b1; d.is_load = 1'b1;
                d.imm = imm_i; d.uop = {1'b0, f3};
            end
            OPC_STORE: begin
                d.is_valid = 1'b1; d.is_store = 1'b1; d.imm = imm_s; d.uop = {1'b0, f3};
            end
            OPC_ARI_ITYPE: begin
                // only SRAI carries the sub/sra bit; an immediate can never make ADDI a SUB
                d.is_valid = 1'b1; d.has_rd = 1'b1; d.imm = imm_i;
                d.uop = {(f7 == FNC7_SUB_SRA) && (f3 == 3'b101), f3};
            end
            OPC_ARI_RTYPE: begin
                // MUL/DIV without M support stays in the bundle but is flagged illegal
                d.is_valid  = (f7 != FNC7_MULDIV) || (SUPPORT_M != 0);
                d.is_muldiv = (f7 == FNC7_MULDIV) && (SUPPORT_M != 0);
                d.has_rd    = 1'b1;
                d.alu_b_sel = 1'b0;
                d.uop       = {f7 == FNC7_SUB_SRA, f3};
            end
            OPC_CSR: begin
                d.is_valid = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

    decoded_inst_t [DEC_WIDTH-1:0] slot;
    decoded_inst_t [DEC_WIDTH-1:0] dec;
    decoded_inst_t [DEC_WIDTH-1:0] acc_slot;
    decoded_inst_t [DEC_WIDTH-1:0] shift_slot;
    logic [TAKE_W-1:0]             cnt;
    logic [TAKE_W-1:0]             take_eff;
    logic [TAKE_W-1:0]             rem;
    logic [TAKE_W-1:0]             acc_cnt;
    logic                          rdy;
    logic                          accept;

    assign take_eff = (dif.rename_take > cnt) ? cnt : dif.rename_take;
    assign rem      = cnt - take_eff;
    assign rdy      = !dif.flush && !rst && !dif.cache_stall && (rem == '0);
    assign accept   = dif.fetch_val && rdy;

    assign dif.decode_rdy  = rdy;
    assign dif.decode_inst = slot;

    always_comb begin
        dec = '0;
        for (int k = 0; k < DEC_WIDTH; k++) begin
            dec[k] = dec_one(dif.fetch_pc[k], dif.fetch_inst[k]);
        end
    end

    // running popcount of the mask gives each valid slot its output position
    always_comb begin
        acc_slot = '0;
        acc_cnt  = '0;
        for (int k = 0; k < DEC_WIDTH; k++) begin
            if (dif.fetch_mask[k]) begin
                for (int p = 0; p < DEC_WIDTH; p++) begin
                    if (TAKE_W'(p) == acc_cnt) begin
                        acc_slot[p] = dec[k];
                    end
                end
                acc_cnt = acc_cnt + TAKE_W'(1);
            end
        end
    end

    always_comb begin
        shift_slot = '0;
        for (int j = 0; j < DEC_WIDTH; j++) begin
            for (int s = 0; s < DEC_WIDTH; s++) begin
                if (s == j + int'(take_eff)) begin
                    shift_slot[j] = slot[s];
                end
            end
        end
    end

    always_comb begin
        dif.decode_val = '0;
        for (int i = 0; i < DEC_WIDTH; i++) begin
            dif.decode_val[i] = (TAKE_W'(i) < cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || dif.flush) begin
            slot <= '0;
            cnt  <= '0;
        end else if (accept) begin
            slot <= acc_slot;
            cnt  <= acc_cnt;
        end else begin
            slot <= shift_slot;
            cnt  <= rem;
        end
    end

endmodule

// File: doc/decode_n.md
Name: decode_n

Overview:
- Parametrised superscalar decode stage. Sits between fetch and rename, and generalises the fixed 2-wide decoder to DEC_WIDTH slots.
- Accepts per-slot fetch valid masks and compacts valid slots to the oldest output positions.
- Supports partial consumption by rename, shifting unconsumed entries down. M-extension decode is optional.
- Output bundle is registered. Uses decoded_inst_t from uarch_pkg.

Parameters:
DEC_WIDTH, 2, number of decode slots (1..8)
SUPPORT_M, 1, 1 = MUL/DIV (OPC_ARI_RTYPE, funct7=FNC7_MULDIV) legal; 0 = such instructions decode with is_valid=0
TAKE_W, $clog2(DEC_WIDTH+1), width of rename consume count (derived, not overridden)

Ports:
clk  in  1  clock, single domain
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush, synchronous, clears held bundle
cache_stall  in  1  blocks acceptance of a new fetch bundle
fetch_pc  in  DEC_WIDTH x CPU_ADDR_BITS  per-slot PC, slot 0 oldest
fetch_inst  in  DEC_WIDTH x CPU_INST_BITS  per-slot instruction
fetch_mask  in  DEC_WIDTH  per-slot valid within bundle
fetch_val  in  1  bundle valid
decode_rdy  out  1  decode accepts the bundle this cycle
decode_inst  out  DEC_WIDTH x decoded_inst_t  held decoded entries, compacted, slot 0 oldest
decode_val  out  DEC_WIDTH  decode_val[i] = (i < cnt)
rename_take  in  TAKE_W  number of oldest valid entries rename consumes this cycle

Behaviour:
- State: slot registers slot[0..DEC_WIDTH-1] and occupancy cnt (0..DEC_WIDTH). Entries 0..cnt-1 are valid. Entries >= cnt are all-zero.
- Reset (rst) or flush: next cycle cnt=0, all slots '0, decode_val=0. Inputs that cycle are ignored. rst/flush has priority over everything.
- take_eff = min(rename_take, cnt). rename_take > cnt is saturated, not an error.
- rem = cnt - take_eff.
- decode_rdy = !flush && !rst && !cache_stall && (rem == 0). This is combinational from rename_take and cnt.
- Accept occurs when fetch_val && decode_rdy:
  - Each slot k with fetch_mask[k]=1 is decoded and placed at output index popcount(fetch_mask[k-1:0]), preserving program order.
  - cnt <= popcount(fetch_mask).
  - A mask of 0 yields cnt=0.
- No accept, and no rst/flush:
  - slot[j] <= slot[j+take_eff] for j+take_eff < DEC_WIDTH; vacated slots are zeroed.
  - cnt <= rem.
  - cache_stall never blocks draining.
- Latency: bundle accepted in cycle N is visible on decode_inst/decode_val in cycle N+1. Throughput is one full bundle per cycle when rename takes all entries.
- Per-slot decode fields:
  - pc, rd=inst[11:7], rs1=inst[19:15], rs2=inst[24:20].
  - is_valid=1 iff opcode is LUI/AUIPC/JAL/JALR/BRANCH/LOAD/STORE/ARI_ITYPE/ARI_RTYPE/CSR, with the muldiv exception when SUPPORT_M=0.
  - Illegal instructions still occupy a slot with decode_val=1 and is_valid=0. Downstream raises the exception.
  - has_rd: LUI/AUIPC/JAL/JALR/LOAD/ITYPE/RTYPE.
  - is_branch, is_jump (JAL, JALR), is_load, is_store. is_muldiv = RTYPE && funct7==FNC7_MULDIV && SUPPORT_M.
  - alu_a_sel=1 (PC) for AUIPC/JAL/BRANCH, else 0.
  - alu_b_sel=0 (rs2) for RTYPE only, else 1.
  - uop: RTYPE = {funct7==FNC7_SUB_SRA, funct3}. ITYPE = same except bit3 set only for funct3=101 (SRAI); ADDI never becomes SUB. LOAD/STORE = {0, funct3}. Else {0, FNC_ADD_SUB}.
  - uop_br = funct3 for BRANCH, else 0.
- Immediates, 32-bit sign-extended:
  - I-type for ITYPE, LOAD, JALR.
  - S-type for STORE.
  - B-type for BRANCH.
  - U-type for LUI/AUIPC.
  - J-type for JAL only.
  - Others 0.
- Simultaneous take and accept: accept is legal only when rem==0, so the new bundle fully replaces the old; no merge.

Test Plan:
- Reset, then fetch_val=1, mask=2'b11, inst0=0x00500093 (addi x1,x0,5), inst1=0x40208233 (sub x4,x1,x2), rename_take=2 → next cycle decode_val=2'b11. Slot0: imm=5, uop=4'b0000, has_rd=1. Slot1: uop=4'b1000, alu_b_sel=0.
- mask=2'b10, inst1=0x0040A103 (lw x2,4(x1)), pc1=0x104 → decode_val=2'b01; slot0: is_load=1, imm=4, pc=0x104, uop=4'b0010.
- Hold bundle of 2, rename_take=1 → decode_rdy=0; next cycle the old slot1 is in slot0, decode_val=2'b01. Then rename_take=1 → decode_rdy=1 and a new bundle is accepted.
- inst=0x00008067 (jalr x0,0(x1)) → is_jump=1, imm=0 (I-type). inst=0x00208463 (beq x1,x2,+8) → is_branch=1, imm=8, alu_a_sel=1, uop_br=0.
- SUPPORT_M=0, inst=0x022081B3 (mul) → decode_val=1, is_valid=0, is_muldiv=0. With SUPPORT_M=1 → is_valid=1, is_muldiv=1.
- Hold cnt=2, assert flush with fetch_val=1 → decode_rdy=0 that cycle; next cycle decode_val=0 and the new bundle is not captured. cache_stall=1 with cnt=2, take=2 → drains to cnt=0 and decode_rdy stays 0.
